// File: rtl/cpu_pkg.sv
// Shared CPU front-end types for the fetch path.
// Contents: XLEN / INST_BYTES widths, word_t, fetch_entry_t (instruction + pc),
// and next_pc() for sequential fetch addresses, which wrap modulo 2^XLEN.
package cpu_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef logic [XLEN-1:0] word_t;

  typedef struct packed {
    word_t data;
    word_t pc;
  } fetch_entry_t;

  // Sequential fetch address; wraps modulo 2^XLEN.
  function automatic word_t next_pc(input word_t pc);
    return pc + word_t'(INST_BYTES);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch queue: synchronous FIFO of fetch_entry_t with DEPTH entries.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push/push_entry write an entry (accepted when not full, or full with pop)
//   pop             drop the head entry (ignored when empty)
//   flush           empty the queue; wins over push and pop
//   head            current head entry
//   empty/full      occupancy flags
//   count           occupancy, 0..DEPTH
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  fetch_entry_t            push_entry,
  input  logic                    pop,
  input  logic                    flush,
  output fetch_entry_t            head,
  output logic                    empty,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  fetch_entry_t    mem [DEPTH];
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr;
  logic            do_pop;
  logic            do_push;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue may still take a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_entry;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch pc, issues word requests to the
// instruction port of memory (at most DEPTH in flight, counting queued
// entries), buffers in-order responses in fetch_queue and hands
// {instruction, pc} to the decoder. A redirect flushes the queue and
// discards responses still in flight.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   mem_req_valid/ready/addr     request channel to memory
//   mem_resp_valid/data          in-order response beats (cannot be stalled)
//   redirect_valid/redirect_pc   single-cycle pc redirect
//   inst_valid/ready/data/pc     decoder handshake
//   misaligned_fault             sticky, set by a redirect to a non-word address
// Optional macro FETCH_BYPASS_EN: when the queue is empty, a response that is
// not being discarded is presented to the decoder in the same cycle it arrives.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH    = 2,
  parameter word_t       RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_req_addr,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        misaligned_fault
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned IW = CW + 1;

  word_t         fetch_pc;
  word_t         resp_pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_nxt;
  logic [CW-1:0] discard;
  logic [CW-1:0] q_count;
  logic [IW-1:0] in_use;
  logic          q_empty;
  logic          q_full;
  logic          q_push;
  logic          q_pop;
  fetch_entry_t  q_head;
  fetch_entry_t  q_in;
  logic          req_fire;
  logic          resp_keep;
  logic          bypass_hit;

  // Credits: requests in flight plus queued entries never exceed DEPTH.
  assign in_use          = IW'(outstanding) + IW'(q_count);
  assign mem_req_valid   = !rst && !redirect_valid && !misaligned_fault &&
                           (in_use < IW'(DEPTH));
  assign mem_req_addr    = fetch_pc;
  assign req_fire        = mem_req_valid && mem_req_ready;
  assign outstanding_nxt = outstanding + CW'(req_fire) - CW'(mem_resp_valid);

  // A response is kept only outside a redirect cycle and once stale beats are drained.
  assign resp_keep = mem_resp_valid && !redirect_valid && (discard == '0);

`ifdef FETCH_BYPASS_EN
  assign bypass_hit = !rst && resp_keep && q_empty;
`else
  assign bypass_hit = 1'b0;
`endif

  // Decoder view: queue head, else the bypassed response, else idle values.
  assign inst_valid = !q_empty || bypass_hit;
  assign inst_data  = !q_empty ? q_head.data : (bypass_hit ? mem_resp_data : '0);
  assign inst_pc    = !q_empty ? q_head.pc : resp_pc;

  assign q_pop  = !q_empty && inst_ready;
  assign q_push = resp_keep && !(bypass_hit && inst_ready);
  assign q_in   = '{data: mem_resp_data, pc: resp_pc};

  fetch_queue #(
    .DEPTH (DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (q_in),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .head       (q_head),
    .empty      (q_empty),
    .full       (q_full),
    .count      (q_count)
  );

  // Fetch/response pcs, in-flight and discard counters, sticky fault.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc         <= RESET_PC;
      resp_pc          <= RESET_PC;
      outstanding      <= '0;
      discard          <= '0;
      misaligned_fault <= 1'b0;
    end else begin
      overflow_chk: assert (redirect_valid || !(q_push && q_full && !q_pop));
      outstanding <= outstanding_nxt;
      if (redirect_valid) begin
        // Everything still in flight after this cycle is stale.
        fetch_pc         <= redirect_pc;
        resp_pc          <= redirect_pc;
        discard          <= outstanding_nxt;
        misaligned_fault <= (redirect_pc[1:0] != 2'b00);
      end else begin
        if (req_fire) begin
          fetch_pc <= next_pc(fetch_pc);
        end
        if (resp_keep) begin
          resp_pc <= next_pc(resp_pc);
        end else if (mem_resp_valid) begin
          discard <= discard - CW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a fixed-latency in-order memory model.
module tb_fetch_unit;
  import cpu_pkg::*;

  localparam int unsigned DEPTH = 2;
`ifdef FETCH_BYPASS_EN
  localparam int LAT_EXP = 1;
`else
  localparam int LAT_EXP = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b1;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        misaligned_fault;

  fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .mem_req_valid    (mem_req_valid),
    .mem_req_ready    (mem_req_ready),
    .mem_req_addr     (mem_req_addr),
    .mem_resp_valid   (mem_resp_valid),
    .mem_resp_data    (mem_resp_data),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .inst_data        (inst_data),
    .inst_pc          (inst_pc),
    .misaligned_fault (misaligned_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  int           lat = 1;
  int           first_acc = -1;
  int           first_vld = -1;
  pend_t        pend[$];
  logic [31:0]  acc_addr[$];
  fetch_entry_t got[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Memory accept side and decoder scoreboard, sampled before the edge updates.
  always @(posedge clk) begin
    if (rst) begin
      pend.delete();
    end else begin
      if (mem_req_valid && mem_req_ready) begin
        pend.push_back('{addr: mem_req_addr, due: cyc + lat});
        acc_addr.push_back(mem_req_addr);
        if (first_acc < 0) first_acc = cyc;
      end
      if (inst_valid && inst_ready) begin
        got.push_back('{data: inst_data, pc: inst_pc});
      end
    end
    cyc = cyc + 1;
  end

  // Memory response side: one beat per cycle, due exactly lat cycles after accept.
  always @(negedge clk) begin
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = mem_word(pend[0].addr);
      pend.delete(0);
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
    end
    #1;
    if (!rst && inst_valid && first_vld < 0) first_vld = cyc;
  end

  task automatic do_reset();
    @(negedge clk);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    inst_ready     = 1'b0;
    mem_req_ready  = 1'b1;
    repeat (2) @(negedge clk);
    got.delete();
    acc_addr.delete();
    first_acc = -1;
    first_vld = -1;
    rst       = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (got.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_count"}, 32'(got.size() >= n), 32'd1);
  endtask

  task automatic check_got(input int i, input logic [31:0] pc, input string tag);
    fetch_entry_t e;
    e = '0;
    if (got.size() > i) e = got[i];
    check({tag, "_pc"}, e.pc, pc);
    check({tag, "_data"}, e.data, mem_word(pc));
  endtask

  task automatic check_acc(input int i, input logic [31:0] addr, input string tag);
    logic [31:0] a;
    a = 32'hDEAD_BEEF;
    if (acc_addr.size() > i) a = acc_addr[i];
    check(tag, a, addr);
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    @(negedge clk);
    redirect_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    #1;
    check("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check("rst_inst_valid", 32'(inst_valid), 32'd0);
    check("rst_inst_data", inst_data, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    check("rst_fault", 32'(misaligned_fault), 32'd0);

    // Streaming, 1-cycle memory, decoder always ready
    do_reset();
    lat        = 1;
    inst_ready = 1'b1;
    wait_got(3, 50, "t1");
    check_got(0, 32'h0, "t1_i0");
    check_got(1, 32'h4, "t1_i1");
    check_got(2, 32'h8, "t1_i2");
    check("t1_latency", 32'(first_vld - first_acc), 32'(LAT_EXP));

    // Decoder stalled: credits stop issue at DEPTH
    do_reset();
    lat        = 1;
    inst_ready = 1'b0;
    repeat (10) @(negedge clk);
    #1;
    check("t2_accepts", 32'(acc_addr.size()), 32'd2);
    check("t2_req_valid", 32'(mem_req_valid), 32'd0);
    check("t2_inst_valid", 32'(inst_valid), 32'd1);
    inst_ready = 1'b1;
    wait_got(2, 20, "t2");
    check_got(0, 32'h0, "t2_i0");
    check_got(1, 32'h4, "t2_i1");

    // Latency-3 memory, redirect with two requests in flight
    do_reset();
    lat        = 3;
    inst_ready = 1'b1;
    for (int k = 0; k < 20 && acc_addr.size() < 2; k++) @(negedge clk);
    check("t3_inflight", 32'(acc_addr.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_got(2, 60, "t3");
    check_got(0, 32'h100, "t3_i0");
    check_got(1, 32'h104, "t3_i1");

    // Redirect coinciding with a decoder handshake on a full queue
    do_reset();
    lat        = 1;
    inst_ready = 1'b0;
    repeat (6) @(negedge clk);
    inst_ready     = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_got(3, 30, "t4");
    check_got(0, 32'h0, "t4_hs");
    check_got(1, 32'h300, "t4_i1");
    check_got(2, 32'h304, "t4_i2");

    // Misaligned redirect sets the fault, aligned redirect clears it
    do_reset();
    lat        = 1;
    inst_ready = 1'b1;
    repeat (3) @(negedge clk);
    redirect(32'h102);
    got.delete();
    for (int k = 0; k < 4; k++) begin
      #1;
      check("t5_req_valid", 32'(mem_req_valid), 32'd0);
      @(negedge clk);
    end
    #1;
    check("t5_fault", 32'(misaligned_fault), 32'd1);
    check("t5_inst_valid", 32'(inst_valid), 32'd0);
    check("t5_no_deliver", 32'(got.size()), 32'd0);
    redirect(32'h200);
    #1;
    check("t5_fault_clr", 32'(misaligned_fault), 32'd0);
    got.delete();
    wait_got(1, 20, "t5");
    check_got(0, 32'h200, "t5_i0");

    // Fetch address wraps at the top of the address space
    do_reset();
    lat        = 1;
    inst_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect(32'hFFFF_FFFC);
    acc_addr.delete();
    got.delete();
    wait_got(2, 20, "t6");
    check_acc(0, 32'hFFFF_FFFC, "t6_req0");
    check_acc(1, 32'h0000_0000, "t6_req1");
    check_got(0, 32'hFFFF_FFFC, "t6_i0");
    check_got(1, 32'h0000_0000, "t6_i1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage directly upstream of the decoder.
- Owns the fetch program counter and issues word requests to the instruction port of memory over a valid/ready request channel.
- Buffers in-order responses in a small prefetch queue and presents {instruction, pc} to the decoder with a valid/ready handshake.
- Handles redirects (branch/jump targets) by flushing the queue and discarding stale in-flight responses.

Parameters:
- DEPTH, 2, prefetch queue entries; also the maximum number of requests in flight (credit limit); power of two, ≥2.
- RESET_PC, 32'h0000_0000, fetch address after reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_req_valid  out  1  request to memory
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  32  word-aligned fetch address
- mem_resp_valid  in  1  response beat; in order, latency ≥1 cycle, cannot be stalled
- mem_resp_data  in  32  instruction word
- redirect_valid  in  1  load new pc; single-cycle pulse
- redirect_pc  in  32  redirect target
- inst_valid  out  1  instruction available to decoder
- inst_ready  in  1  decoder consumes
- inst_data  out  32  instruction word
- inst_pc  out  32  address of inst_data
- misaligned_fault  out  1  sticky; redirect_pc[1:0] != 0

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - mem_req_valid=0, inst_valid=0, inst_data=0, inst_pc=RESET_PC, misaligned_fault=0.
  - fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard=0, queue empty.
- Reset mid-operation: all state is cleared. Responses arriving after reset for pre-reset requests are a memory-side error; the memory is reset on the same rst.
- Request issue (credits):
  - mem_req_valid = !rst && !redirect_valid && !misaligned_fault && (outstanding + occupancy < DEPTH).
  - mem_req_addr = fetch_pc. It stays stable while valid && !ready, except when a redirect withdraws the request.
  - Accept (valid && ready): fetch_pc += 4 (wraps modulo 2^32), outstanding++.
- Response handling:
  - Every mem_resp_valid decrements outstanding.
  - If discard > 0: discard--, data dropped.
  - Else: push {mem_resp_data, resp_pc} into the queue and increment resp_pc by 4.
  - The credit rule guarantees the queue never overflows. Overflow is an assertion failure.
- Output:
  - inst_valid = queue not empty; inst_data and inst_pc come from the queue head.
  - Pop on inst_valid && inst_ready.
  - Base latency: request accepted cycle N, response cycle N+k, inst_valid at N+k+1.
  - Push and pop in the same cycle on a full queue is legal. The response is pushed, occupancy is unchanged, and credit is unaffected since outstanding drops.
- Redirect (priority over everything except rst):
  - A consumer handshake in the same cycle is honoured: the instruction counts as consumed.
  - The queue is flushed.
  - discard <= outstanding_after_this_cycle. Any response arriving in the redirect cycle is dropped and is not counted in discard.
  - fetch_pc and resp_pc <= redirect_pc.
  - mem_req_valid=0 in the redirect cycle; the first request to redirect_pc appears the next cycle.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - misaligned_fault=1 and issue stops; the queue is flushed.
  - Only rst or a later aligned redirect clears the fault; issue then resumes.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Counter widths: outstanding and discard are $clog2(DEPTH)+1 bits and never exceed DEPTH.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined: when the queue is empty, discard==0 and mem_resp_valid, the response is presented combinationally the same cycle. inst_data=mem_resp_data, inst_pc=resp_pc, inst_valid=1. If inst_ready, the response is not pushed. Zero-bubble latency N+k.
- Undefined: every response passes through the queue. The output is purely registered, with latency N+k+1.

Decomposition:
- cpu_pkg:
  - XLEN=32; INST_BYTES=4.
  - typedef word_t (logic [XLEN-1:0]).
  - typedef struct fetch_entry_t {word_t data; word_t pc;}.
- Sub-module fetch_queue: synchronous FIFO of fetch_entry_t with DEPTH entries. It has push, pop, flush, empty, full, count. Flush wins over push.

Test Plan:
- Reset release, memory always ready, 1-cycle response, inst_ready=1:
  - inst_pc sequence 0x0, 0x4, 0x8.
  - First inst_valid 2 cycles after the first accept (1 cycle with FETCH_BYPASS_EN).
- inst_ready=0 for 10 cycles, DEPTH=2:
  - Exactly 2 requests are accepted, then mem_req_valid=0.
  - Releasing ready delivers 0x0 then 0x4 in order with no loss.
- Latency-3 memory, redirect to 0x100 with 2 requests in flight:
  - Both stale responses are dropped.
  - The next inst_pc is 0x100 with the data at 0x100.
- Redirect and inst handshake in the same cycle:
  - The handshaked instruction is counted once.
  - Nothing older is delivered afterwards.
- Redirect to 0x102:
  - misaligned_fault=1, mem_req_valid stays 0.
  - A subsequent redirect to 0x200 clears the fault and fetches 0x200.
- fetch_pc=0xFFFF_FFFC:
  - The next request address wraps to 0x0000_0000.
  - inst_pc follows 0xFFFF_FFFC then 0x0.
